// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Pong game flow controller for serve, play, point and game-over.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int SERVE_CLKS = 25_000_000,
  parameter int POINT_CLKS = 50_000_000,
  parameter int WIN_SCORE  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_enable,
  output logic       ball_recenter,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam int MAX_CLKS = (SERVE_CLKS > POINT_CLKS) ? SERVE_CLKS : POINT_CLKS;
  localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_CLKS - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      cnt           <= '0;
      score_left    <= '0;
      score_right   <= '0;
      serve_dir     <= 1'b0;
      ball_enable   <= 1'b0;
      ball_recenter <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      ball_recenter <= 1'b0;
      ball_enable   <= 1'b0;
      case (st)
        IDLE, OVER: begin
          if (start) begin
            st            <= SERVE;
            cnt           <= '0;
            score_left    <= '0;
            score_right   <= '0;
            serve_dir     <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
            ball_recenter <= 1'b1;
          end
        end
        SERVE: begin
          if (cnt == SERVE_LAST) begin
            st          <= PLAY;
            cnt         <= '0;
            ball_enable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PLAY: begin
          ball_enable <= 1'b1;
          // Simultaneous misses cancel: nobody scores, the rally is replayed.
          if (miss_left && miss_right) begin
            st          <= POINT;
            cnt         <= '0;
            ball_enable <= 1'b0;
          end else if (miss_left) begin
            score_right <= score_right + 4'd1;
            serve_dir   <= 1'b1;
            cnt         <= '0;
            ball_enable <= 1'b0;
            if (score_right + 4'd1 == WIN) begin
              st        <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              st <= POINT;
            end
          end else if (miss_right) begin
            score_left  <= score_left + 4'd1;
            serve_dir   <= 1'b0;
            cnt         <= '0;
            ball_enable <= 1'b0;
            if (score_left + 4'd1 == WIN) begin
              st        <= OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              st <= POINT;
            end
          end
        end
        POINT: begin
          if (cnt == POINT_LAST) begin
            st            <= SERVE;
            cnt           <= '0;
            ball_recenter <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// Testbench for pong_game_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a phase/timer reference model.
module tb_pong_game_ctrl;

  localparam int S = 4;
  localparam int P = 3;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_enable, ball_recenter, serve_dir, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  pong_game_ctrl #(.SERVE_CLKS(S), .POINT_CLKS(P), .WIN_SCORE(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_enable(ball_enable), .ball_recenter(ball_recenter),
    .serve_dir(serve_dir), .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: game phase plus remaining-cycle timer.
  int m_phase, m_left_cyc, m_sl, m_sr, m_dir, m_go, m_win, m_rec;

  function automatic logic [15:0] pack(input logic [2:0] st, input logic en,
      input logic rec, input logic dir, input logic [3:0] sl,
      input logic [3:0] sr, input logic go, input logic win);
    return {st, en, rec, dir, sl, sr, go, go & win};
  endfunction

  function automatic logic [15:0] dut_vec();
    return pack(state, ball_enable, ball_recenter, serve_dir, score_left,
                score_right, game_over, winner);
  endfunction

  function automatic logic [15:0] model_vec();
    return pack(3'(m_phase), m_phase == 2, 1'(m_rec), 1'(m_dir), 4'(m_sl),
                4'(m_sr), 1'(m_go), 1'(m_win));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left_cyc = 0; m_sl = 0; m_sr = 0;
    m_dir = 0; m_go = 0; m_win = 0; m_rec = 0;
  endtask

  task automatic model_step(input bit s, input bit ml, input bit mr);
    m_rec = 0;
    case (m_phase)
      0, 4: if (s) begin
        m_phase = 1; m_left_cyc = S; m_sl = 0; m_sr = 0;
        m_dir = 0; m_go = 0; m_win = 0; m_rec = 1;
      end
      1: begin
        m_left_cyc--;
        if (m_left_cyc == 0) m_phase = 2;
      end
      2: begin
        if (ml && mr) begin
          m_phase = 3; m_left_cyc = P;
        end else if (ml || mr) begin
          if (ml) begin m_sr++; m_dir = 1; end
          else    begin m_sl++; m_dir = 0; end
          if ((ml ? m_sr : m_sl) == W) begin
            m_phase = 4; m_go = 1; m_win = ml ? 1 : 0;
          end else begin
            m_phase = 3; m_left_cyc = P;
          end
        end
      end
      3: begin
        m_left_cyc--;
        if (m_left_cyc == 0) begin m_phase = 1; m_left_cyc = S; m_rec = 1; end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, take the edge, advance the model.
  task automatic tick(input bit s, input bit ml, input bit mr);
    start = s; miss_left = ml; miss_right = mr;
    @(posedge clk);
    #1;
    model_step(s, ml, mr);
    start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task automatic tick_chk(input string name, input bit s, input bit ml, input bit mr);
    tick(s, ml, mr);
    check(name, dut_vec(), model_vec());
  endtask

  task automatic go_play();
    int n = 0;
    while (m_phase != 2 && n < 20) begin
      tick_chk("to_play", 1'b0, 1'b0, 1'b0);
      n++;
    end
    if (m_phase != 2) begin
      total++; bad++;
      $display("FAIL go_play: timeout, model phase %0d", m_phase);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit s, ml, mr;
    logic [2:0] st;
    bit en, rec, dir;
    logic [3:0] sl, sr;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(bit s, bit ml, bit mr, logic [2:0] st, bit en,
      bit rec, bit dir, logic [3:0] sl, logic [3:0] sr);
    vec_t v;
    v.s = s; v.ml = ml; v.mr = mr; v.st = st; v.en = en; v.rec = rec;
    v.dir = dir; v.sl = sl; v.sr = sr;
    return v;
  endfunction

  initial begin
    //            s ml mr  st en rec dir sl sr
    tbl[0]  = mk(1, 0, 0,  1, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  2, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0,  3, 0, 0, 1, 0, 1);
    tbl[6]  = mk(0, 1, 0,  3, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 0, 1,  3, 0, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 0,  1, 0, 1, 1, 0, 1);
    tbl[9]  = mk(0, 1, 0,  1, 0, 0, 1, 0, 1);
    tbl[10] = mk(0, 0, 1,  1, 0, 0, 1, 0, 1);
    tbl[11] = mk(0, 0, 0,  1, 0, 0, 1, 0, 1);
    tbl[12] = mk(0, 0, 0,  2, 1, 0, 1, 0, 1);
    tbl[13] = mk(0, 1, 1,  3, 0, 0, 1, 0, 1);
    tbl[14] = mk(1, 0, 0,  3, 0, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0,  3, 0, 0, 1, 0, 1);
    tbl[16] = mk(0, 0, 0,  1, 0, 1, 1, 0, 1);
    tbl[17] = mk(1, 0, 0,  1, 0, 0, 1, 0, 1);
    tbl[18] = mk(0, 0, 0,  1, 0, 0, 1, 0, 1);
    tbl[19] = mk(0, 0, 0,  1, 0, 0, 1, 0, 1);
    tbl[20] = mk(0, 0, 0,  2, 1, 0, 1, 0, 1);
    tbl[21] = mk(1, 0, 0,  2, 1, 0, 1, 0, 1);
    tbl[22] = mk(0, 0, 1,  3, 0, 0, 0, 1, 1);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick_chk("idle_hold", 1'b0, 1'b1, 1'b1);

    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].ml, tbl[i].mr);
      check($sformatf("vec%0d", i), dut_vec(),
            pack(tbl[i].st, tbl[i].en, tbl[i].rec, tbl[i].dir,
                 tbl[i].sl, tbl[i].sr, 1'b0, 1'b0));
    end

    // Left player wins 3-0; a further miss must not move the score.
    do_reset();
    tick_chk("start", 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      go_play();
      tick_chk("miss_right", 1'b0, 1'b0, 1'b1);
    end
    check("win_outputs", dut_vec(), pack(3'd4, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0));
    check_int("winner_left", int'(winner), 0);
    tick(1'b0, 1'b0, 1'b1);
    check("over_frozen", dut_vec(), pack(3'd4, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0));

    // Restart from OVER.
    tick(1'b1, 1'b0, 1'b0);
    check("restart", dut_vec(), pack(3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    tick(1'b0, 1'b0, 1'b0);
    check_int("recenter_one_cycle", int'(ball_recenter), 0);

    // Right player wins: winner must be 1.
    repeat (3) begin
      go_play();
      tick_chk("miss_left", 1'b0, 1'b1, 1'b0);
    end
    check("right_wins", dut_vec(), pack(3'd4, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 1'b1, 1'b1));

    // Reach 2-1 in PLAY, then reset mid-rally.
    tick_chk("start2", 1'b1, 1'b0, 1'b0);
    go_play(); tick_chk("l1", 1'b0, 1'b0, 1'b1);
    go_play(); tick_chk("l2", 1'b0, 1'b0, 1'b1);
    go_play(); tick_chk("r1", 1'b0, 1'b1, 1'b0);
    go_play();
    check("pre_reset_2_1", dut_vec(), pack(3'd2, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 1'b0, 1'b0));
    do_reset();
    tick_chk("idle_after_reset", 1'b0, 1'b1, 1'b0);
    tick_chk("idle_after_reset2", 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("restart_0_0", dut_vec(), pack(3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick_chk("random", $urandom_range(0, 7) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
        if (ball_recenter && m_rec == 1 && m_phase != 1)
          check_int("recenter_in_serve", m_phase, 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
